// File: rtl/basilisk_writeback.sv
// Writeback collector: round-robin merge of result-slice streams into the single
// vector register file write port, with per-register slice completion tracking.
module basilisk_writeback #(
  parameter int NUM_INPUTS    = 4,
  parameter int VECTOR_WIDTH  = 16,
  parameter int COMPUTE_WIDTH = 8,
  parameter int NUM_OFFSETS   = VECTOR_WIDTH / COMPUTE_WIDTH,
  parameter int OFFSET_WIDTH  = (NUM_OFFSETS > 1) ? $clog2(NUM_OFFSETS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_INPUTS-1:0]                 in_valid,
  output logic [NUM_INPUTS-1:0]                 in_ready,
  input  logic [NUM_INPUTS*5-1:0]               in_reg_addr,
  input  logic [NUM_INPUTS*OFFSET_WIDTH-1:0]    in_offset,
  input  logic [NUM_INPUTS*COMPUTE_WIDTH*32-1:0] in_data,
  output logic                                  wr_enable,
  output logic [4:0]                            wr_reg_addr,
  output logic [OFFSET_WIDTH-1:0]               wr_offset,
  output logic [COMPUTE_WIDTH*32-1:0]           wr_data,
  output logic                                  done_valid,
  output logic [4:0]                            done_reg_addr,
  output logic                                  error
);
  localparam int PTR_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int DATA_W = COMPUTE_WIDTH * 32;

  logic [PTR_W-1:0]        ptr;
  logic [NUM_INPUTS-1:0]   grant;
  logic [PTR_W-1:0]        grant_idx;
  logic                    accept;
  logic [4:0]              sel_reg;
  logic [OFFSET_WIDTH-1:0] sel_off;
  logic [DATA_W-1:0]       sel_data;
  logic                    bad_off;
  logic                    dup;
  logic                    complete;
  logic [NUM_OFFSETS-1:0]  cur_mask;
  logic [NUM_OFFSETS-1:0]  new_mask;
  logic [NUM_OFFSETS-1:0]  written [32];

  // Handshake: a beat transfers on stream i when in_valid[i] && in_ready[i] at the
  // rising edge; in_ready is the arbiter grant and never depends on downstream state.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    // Scan from farthest to nearest so the first valid at/after ptr wins last.
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_INPUTS;
      if (in_valid[idx] && !rst) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

  assign in_ready = grant;
  assign accept   = |grant;

  always_comb begin
    int gi;
    gi       = int'(grant_idx);
    sel_reg  = in_reg_addr[gi*5 +: 5];
    sel_off  = in_offset[gi*OFFSET_WIDTH +: OFFSET_WIDTH];
    sel_data = in_data[gi*DATA_W +: DATA_W];
    bad_off  = (32'(sel_off) >= 32'(NUM_OFFSETS));
    cur_mask = written[sel_reg];
    dup      = !bad_off && cur_mask[sel_off];
    new_mask = cur_mask | (NUM_OFFSETS'(1) << sel_off);
    complete = &new_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      wr_enable     <= 1'b0;
      wr_reg_addr   <= '0;
      wr_offset     <= '0;
      wr_data       <= '0;
      done_valid    <= 1'b0;
      done_reg_addr <= '0;
      error         <= 1'b0;
      for (int r = 0; r < 32; r++) written[r] <= '0;
    end else begin
      wr_enable  <= accept && !bad_off;
      done_valid <= accept && !bad_off && complete;
      if (accept) begin
        ptr <= (int'(grant_idx) == NUM_INPUTS - 1) ? '0 : grant_idx + 1'b1;
        if (bad_off || dup) error <= 1'b1;
        if (!bad_off) begin
          wr_reg_addr      <= sel_reg;
          wr_offset        <= sel_off;
          wr_data          <= sel_data;
          // A completed register restarts with an empty mask for its next writer.
          written[sel_reg] <= complete ? '0 : new_mask;
          if (complete) done_reg_addr <= sel_reg;
        end
      end
    end
  end
endmodule

// File: tb/tb_basilisk_writeback.sv
// Bench for basilisk_writeback: directed vector table, then random traffic checked
// against a slice-set model with an expected-write queue.
module tb_basilisk_writeback;
  localparam int NI = 4;
  localparam int CW = 8;
  localparam int DW = CW * 32;
  localparam int OW = 1;
  localparam int NOFF = 2;
  localparam int EW = 1 + 5 + 5 + 1 + DW;

  logic clk = 1'b0;
  logic rst;
  logic [NI-1:0]    in_valid;
  logic [NI-1:0]    in_ready;
  logic [NI*5-1:0]  in_reg_addr;
  logic [NI*OW-1:0] in_offset;
  logic [NI*DW-1:0] in_data;
  logic             wr_enable;
  logic [4:0]       wr_reg_addr;
  logic [OW-1:0]    wr_offset;
  logic [DW-1:0]    wr_data;
  logic             done_valid;
  logic [4:0]       done_reg_addr;
  logic             error;

  basilisk_writeback dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_addr(in_reg_addr), .in_offset(in_offset), .in_data(in_data),
    .wr_enable(wr_enable), .wr_reg_addr(wr_reg_addr), .wr_offset(wr_offset),
    .wr_data(wr_data), .done_valid(done_valid), .done_reg_addr(done_reg_addr),
    .error(error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: pointer, set of landed slices per register, sticky error.
  int   m_ptr = 0;
  bit   m_seen [32][NOFF];
  int   m_landed [32];
  bit   m_err = 1'b0;
  logic [EW-1:0] exp_q[$];

  function automatic logic [3:0] model_grant(input logic r, input logic [3:0] v);
    logic [3:0] g;
    g = '0;
    if (!r) begin
      for (int k = 0; k < NI; k++) begin
        int idx;
        idx = (m_ptr + k) % NI;
        if (g == 0 && v[idx]) g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] v, input logic [3:0][4:0] regs,
                            input logic [3:0] offs, input logic [31:0] word);
    logic [3:0] g;
    if (r) begin
      m_ptr = 0;
      m_err = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
        m_landed[i] = 0;
        for (int j = 0; j < NOFF; j++) m_seen[i][j] = 1'b0;
      end
    end else begin
      g = model_grant(1'b0, v);
      for (int s = 0; s < NI; s++) begin
        if (g[s]) begin
          int rg, of;
          logic fin;
          logic [31:0] ws;
          rg = int'(regs[s]);
          of = int'(offs[s]);
          ws = word ^ 32'(s);
          if (m_seen[rg][of]) m_err = 1'b1;
          else begin
            m_seen[rg][of] = 1'b1;
            m_landed[rg]++;
          end
          fin = (m_landed[rg] == NOFF);
          if (fin) begin
            m_landed[rg] = 0;
            for (int j = 0; j < NOFF; j++) m_seen[rg][j] = 1'b0;
          end
          exp_q.push_back({fin, regs[s], regs[s], offs[s], {8{ws}}});
          m_ptr = (s + 1) % NI;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_enable", DW'(wr_enable), DW'(1));
      chk("wr_reg_addr", DW'(wr_reg_addr), DW'(e[261:257]));
      chk("wr_offset", DW'(wr_offset), DW'(e[256]));
      chk("wr_data", wr_data, e[255:0]);
      chk("done_valid", DW'(done_valid), DW'(e[267]));
      if (e[267]) chk("done_reg_addr", DW'(done_reg_addr), DW'(e[266:262]));
    end else begin
      chk("wr_enable_idle", DW'(wr_enable), DW'(0));
      chk("done_valid_idle", DW'(done_valid), DW'(0));
    end
    chk("error", DW'(error), DW'(m_err));
  endtask

  // One clock: drive at negedge, check in_ready, model at posedge, check outputs at negedge.
  task automatic cycle(input logic r, input logic [3:0] v, input logic [3:0][4:0] regs,
                       input logic [3:0] offs, input logic [31:0] word,
                       output logic [3:0] rdy, output logic wr, output logic dn,
                       output logic [4:0] dreg, output logic er);
    logic [3:0] eg;
    rst      = r;
    in_valid = v;
    for (int s = 0; s < NI; s++) begin
      in_reg_addr[s*5 +: 5] = regs[s];
      in_offset[s]          = offs[s];
      in_data[s*DW +: DW]   = {8{word ^ 32'(s)}};
    end
    #1;
    eg  = model_grant(r, v);
    rdy = in_ready;
    chk("in_ready", DW'(in_ready), DW'(eg));
    @(posedge clk);
    model_step(r, v, regs, offs, word);
    @(negedge clk);
    check_outputs();
    wr   = wr_enable;
    dn   = done_valid;
    dreg = done_reg_addr;
    er   = error;
  endtask

  typedef struct {
    logic            r;
    logic [3:0]      v;
    logic [3:0][4:0] regs;
    logic [3:0]      offs;
    logic [31:0]     word;
    logic [3:0]      exp_ready;
    logic            exp_wr;
    logic            exp_done;
    logic [4:0]      exp_dreg;
    logic            exp_err;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [4:0] rg,
                              input logic spread, input logic [3:0] offs, input logic [31:0] w,
                              input logic [3:0] er, input logic ew, input logic ed,
                              input logic [4:0] edr, input logic ee);
    vec_t t;
    t.r = r; t.v = v; t.offs = offs; t.word = w;
    for (int s = 0; s < NI; s++) t.regs[s] = spread ? rg + 5'(s) : rg;
    t.exp_ready = er; t.exp_wr = ew; t.exp_done = ed; t.exp_dreg = edr; t.exp_err = ee;
    return t;
  endfunction

  vec_t tbl[$];
  int   acc_cnt [NI];

  initial begin
    logic [3:0] rdy;
    logic wr, dn, er;
    logic [4:0] dreg;
    logic [3:0][4:0] rregs;

    rst = 1'b1; in_valid = '0; in_reg_addr = '0; in_offset = '0; in_data = '0;
    for (int s = 0; s < NI; s++) acc_cnt[s] = 0;
    for (int i = 0; i < 32; i++) m_landed[i] = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr_enable", DW'(wr_enable), DW'(0));
    chk("rst_wr_reg_addr", DW'(wr_reg_addr), DW'(0));
    chk("rst_wr_offset", DW'(wr_offset), DW'(0));
    chk("rst_wr_data", wr_data, DW'(0));
    chk("rst_done_valid", DW'(done_valid), DW'(0));
    chk("rst_done_reg_addr", DW'(done_reg_addr), DW'(0));
    chk("rst_error", DW'(error), DW'(0));
    chk("rst_in_ready", DW'(in_ready), DW'(0));

    tbl.push_back(mk(1, 4'hF, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 4'hF, 10, 1, (i < 4) ? 4'h0 : 4'hF, 32'h1000 + 32'(i),
                       4'(1 << (i % 4)), 1, i >= 4, 5'(10 + i % 4), 0));
    tbl.push_back(mk(0, 4'h1, 3, 0, 4'h0, 32'h3F800000, 4'h1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'h1, 3, 0, 4'hF, 32'h40000000, 4'h1, 1, 1, 3, 0));
    tbl.push_back(mk(0, 4'h1, 5, 0, 4'h0, 32'h00000505, 4'h1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'h2, 7, 0, 4'h0, 32'h00000707, 4'h2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'h2, 7, 0, 4'hF, 32'h00017070, 4'h2, 1, 1, 7, 0));
    tbl.push_back(mk(0, 4'h1, 5, 0, 4'hF, 32'h00015050, 4'h1, 1, 1, 5, 0));
    tbl.push_back(mk(0, 4'h1, 9, 0, 4'h0, 32'h09090909, 4'h1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'h1, 9, 0, 4'h0, 32'h90909090, 4'h1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 4'h1, 9, 0, 4'hF, 32'h99999999, 4'h1, 1, 1, 9, 1));
    tbl.push_back(mk(0, 4'h1, 2, 0, 4'h0, 32'h22220000, 4'h1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 4'h0, 2, 0, 4'h0, 32'h0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h1, 2, 0, 4'hF, 32'h22221111, 4'h1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'h1, 2, 0, 4'h0, 32'h22222222, 4'h1, 1, 1, 2, 0));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h4, 20, 0, 4'h0, 32'hABCD0000, 4'h4, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 21, 1, 4'h0, 32'hABCD1111, 4'h8, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'h2, 7, 0, 4'h0, 32'h77770000, 4'h2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'h2, 7, 0, 4'hF, 32'h77771111, 4'h2, 1, 1, 7, 0));
    tbl.push_back(mk(0, 4'h2, 7, 0, 4'hF, 32'h77772222, 4'h2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'h2, 7, 0, 4'h0, 32'h77773333, 4'h2, 1, 1, 7, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].regs, tbl[i].offs, tbl[i].word, rdy, wr, dn, dreg, er);
      chk($sformatf("tbl_ready[%0d]", i), DW'(rdy), DW'(tbl[i].exp_ready));
      chk($sformatf("tbl_wr[%0d]", i), DW'(wr), DW'(tbl[i].exp_wr));
      chk($sformatf("tbl_done[%0d]", i), DW'(dn), DW'(tbl[i].exp_done));
      if (tbl[i].exp_done) chk($sformatf("tbl_done_reg[%0d]", i), DW'(dreg), DW'(tbl[i].exp_dreg));
      chk($sformatf("tbl_err[%0d]", i), DW'(er), DW'(tbl[i].exp_err));
      if (i >= 1 && i <= 8)
        for (int s = 0; s < NI; s++) if (rdy[s] && tbl[i].v[s]) acc_cnt[s]++;
    end
    for (int s = 0; s < NI; s++) chk($sformatf("rr_accepts[%0d]", s), DW'(acc_cnt[s]), DW'(2));

    for (int i = 0; i < 500; i++) begin
      for (int s = 0; s < NI; s++) rregs[s] = 5'($urandom_range(0, 3));
      cycle(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)), rregs,
            4'($urandom_range(0, 15)), $urandom, rdy, wr, dn, dreg, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
